// File: rtl/hbm_delay_line.sv
// hbm_delay_line: in-order delay line that releases each request Leff cycles after acceptance.
//   clk_i/rst_ni   clock, asynchronous active-low reset
//   flush_i        synchronous clear of all entries
//   in_*/lat_i     request handshake, payload and per-request delay
//   out_*          response handshake and payload
//   count_o        current occupancy
module hbm_delay_line #(
  parameter int DataWidth  = 64,
  parameter int MaxLatency = 100,
  parameter int Depth      = 32,
  parameter int LatWidth   = $clog2(MaxLatency+1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DataWidth-1:0]         in_data_i,
  input  logic [LatWidth-1:0]          lat_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DataWidth-1:0]         out_data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);
  localparam int CntW = $clog2(Depth+1);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;

  if (DataWidth < 1) begin : g_bad_dw
    $error("DataWidth must be >= 1");
  end
  if (Depth < 1) begin : g_bad_depth
    $error("Depth must be >= 1");
  end
  if (MaxLatency < 1) begin : g_bad_lat
    $error("MaxLatency must be >= 1");
  end
  if (LatWidth < $clog2(MaxLatency+1)) begin : g_bad_lw
    $error("LatWidth too small for MaxLatency");
  end

  logic [DataWidth-1:0] data_q [Depth];
  logic [LatWidth-1:0]  cd_q [Depth];
  logic [LatWidth-1:0]  cd_d [Depth];
  logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [LatWidth-1:0]  leff;
  logic                 push, pop;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth-1) ? '0 : p + PtrW'(1);
  endfunction

  // Countdowns tick in every slot regardless of FIFO position; the head
  // alone decides release, giving in-order output with head-of-line blocking.
  always_comb begin
    in_ready_o  = cnt_q < CntW'(Depth) && !flush_i;
    out_valid_o = cnt_q != '0 && cd_q[rd_q] == '0;
    out_data_o  = data_q[rd_q];
    count_o     = cnt_q;
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i && !flush_i;
    leff        = lat_i == '0 ? LatWidth'(1) :
                  lat_i > LatWidth'(MaxLatency) ? LatWidth'(MaxLatency) : lat_i;
    wr_d        = flush_i ? '0 : push ? nxt(wr_q) : wr_q;
    rd_d        = flush_i ? '0 : pop ? nxt(rd_q) : rd_q;
    cnt_d       = flush_i ? '0 : cnt_q + CntW'(push) - CntW'(pop);
    for (int i = 0; i < Depth; i++)
      cd_d[i] = flush_i ? '0 :
                (push && wr_q == PtrW'(i)) ? leff - LatWidth'(1) :
                cd_q[i] != '0 ? cd_q[i] - LatWidth'(1) : cd_q[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) cd_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < Depth; i++) cd_q[i] <= cd_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) data_q[wr_q] <= in_data_i;
  end
endmodule

// File: doc/hbm_delay_line.md
HBM_DELAY_LINE -- requirements
Module: hbm_delay_line

Interface
REQ-001 SHALL have parameter DataWidth, default 64, payload width in bits.
REQ-002 SHALL have parameter MaxLatency, default 100, largest delay in cycles; the default equals the HBM latency used by the compute-tile array bench.
REQ-003 SHALL have parameter Depth, default 32, maximum outstanding entries; the default equals the wide per-ID transaction limit.
REQ-004 SHALL have parameter LatWidth, default $clog2(MaxLatency+1), width of lat_i.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush_i  input  1  synchronous clear of all entries.
REQ-008 SHALL have port in_valid_i  input  1  request valid.
REQ-009 SHALL have port in_ready_o  output  1  request accepted when both high.
REQ-010 SHALL have port in_data_i  input  DataWidth  request payload.
REQ-011 SHALL have port lat_i  input  LatWidth  per-request delay, sampled at handshake.
REQ-012 SHALL have port out_valid_o  output  1  response valid.
REQ-013 SHALL have port out_ready_i  input  1  response consumed when both high.
REQ-014 SHALL have port out_data_o  output  DataWidth  response payload.
REQ-015 SHALL have port count_o  output  $clog2(Depth+1)  current occupancy.

Function
REQ-016 SHALL store entries in a FIFO of Depth slots; read and write pointers wrap modulo Depth; Depth need not be a power of two.
REQ-017 SHALL drive in_ready_o = (count_o < Depth) && !flush_i; there is no same-cycle bypass when full.
REQ-018 SHALL compute effective latency Leff = 1 if lat_i == 0, MaxLatency if lat_i > MaxLatency, else lat_i.
REQ-019 SHALL, on input handshake in cycle T, write payload plus countdown = Leff-1 into the write slot at the edge ending T.
REQ-020 SHALL decrement every occupied slot's countdown by 1 each cycle while it is nonzero, independent of FIFO position; a countdown of zero SHALL hold at zero.
REQ-021 SHALL drive out_valid_o = head occupied && head countdown == 0, so a request accepted in cycle T produces out_valid_o no earlier than cycle T+Leff.
REQ-022 SHALL release strictly in acceptance order; an expired entry behind an unexpired head waits (head-of-line blocking).
REQ-023 SHALL, once out_valid_o is high, hold it and out_data_o stable until the out_ready_i handshake.
REQ-024 SHALL, on simultaneous push and pop, perform both and leave count_o unchanged.
REQ-025 SHALL, when flush_i is high, empty the FIFO at the next edge (count_o=0, pointers=0); flush takes priority over push and pop in the same cycle; out_valid_o may still be high during the flush cycle, and no handshake completes in that cycle.
REQ-026 SHALL drive out_data_o as the head slot payload; the value is don't-care while out_valid_o is low.
REQ-027 SHALL carry elaboration assertions that DataWidth >= 1, Depth >= 1, MaxLatency >= 1 and LatWidth >= $clog2(MaxLatency+1).

Reset
REQ-028 SHALL, while rst_ni is low, asynchronously force count_o=0, out_valid_o=0, pointers=0 and all countdowns=0, with in_ready_o=1 once the flush_i term allows.
REQ-029 SHALL discard all in-flight entries on reset mid-operation, with no output after release unless new requests are accepted.

Verification
REQ-030 SHALL cover: defaults, push 0xA5 with lat_i=100 in cycle 5, out_ready_i=1 -> out_valid_o first high in cycle 105 with out_data_o=0xA5, then low in cycle 106.
REQ-031 SHALL cover: out_ready_i=0, 33 back-to-back pushes with lat_i=4 -> in_ready_o low after the 32nd accept, count_o=32; raising out_ready_i -> values 0..31 leave in order, one per cycle, and the 33rd is accepted the cycle after the first pop.
REQ-032 SHALL cover: push A lat_i=20 in cycle 0, then B lat_i=2 in cycle 1 -> A out in cycle 20 and B in cycle 21, never before A.
REQ-033 SHALL cover: lat_i=0 -> out_valid_o one cycle after the handshake; with MaxLatency=100 and lat_i=127 -> 100-cycle delay.
REQ-034 SHALL cover: 5 entries held, flush_i pulsed simultaneously with in_valid_i -> in_ready_o low that cycle, count_o=0 and out_valid_o=0 next cycle, and no stale output afterwards.
REQ-035 SHALL cover: rst_ni asserted asynchronously mid-cycle with 3 entries pending -> outputs at reset values immediately, and no output within 200 cycles after release.
